shared_adder_arbiter: RTL
=========================

Name: shared_adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit adder and one unsigned comparator among 8 requesters.
- Each request carries two operands. The block grants one requester, latches that requester's operands, and evaluates sum, greater and equal on the shared units.
- It returns the results tagged with the requester id.
- It sits between client blocks and the shared arithmetic resource.

Parameters:
WIDTH, 32, operand and result width in bits (number of requesters fixed at 8, id width fixed at 3)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  8  request vector, bit i = requester i; level, held until granted
op_a  input  8*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
op_b  input  8*WIDTH  operand B, same packing as op_a
grant  output  8  one-hot, one-cycle pulse: operands of that requester accepted
busy  output  1  high whenever FSM is not IDLE
result_valid  output  1  one-cycle pulse: result fields valid
result_id  output  3  index of requester the result belongs to
result_sum  output  WIDTH  (A + B) mod 2^WIDTH; carry discarded
result_greater  output  1  A > B, unsigned
result_equal  output  1  A == B

Behaviour:
- Reset (async, any time):
  - State returns to IDLE; rr pointer ptr = 7.
  - All outputs go to 0: grant, busy, result_valid, result_id, result_sum, result_greater, result_equal.
  - An in-flight operation is discarded and no result_valid is produced for it.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE, which holds while req == 0.
- IDLE, at the edge where req != 0:
  - Select winner w by rotating priority. Search order is ptr+1, ptr+2, …, ptr (mod 8), and the first set bit wins.
  - Latch w, op_a[w] and op_b[w].
  - Go to EXEC; grant register = one-hot(w).
- EXEC:
  - grant is visible this cycle only; busy = 1.
  - At the closing edge, register the adder/comparator outputs computed from the latched operands and set result_valid.
  - Go to RESP.
- RESP:
  - result_valid = 1 and result_id = w; result fields are stable; busy = 1.
  - At the closing edge: ptr <= w, result_valid <= 0, go to IDLE.
- Result fields hold their last values after RESP until the next EXEC edge overwrites them.
- Latency: req sampled at edge k -> grant high in cycle k+1 -> result_valid high in cycle k+2 -> next arbitration at edge k+3. Throughput is one operation per 3 cycles.
- Requester obligations:
  - Drop req before edge k+3, or it is treated as a new request.
  - Operands need only be valid at the arbitration edge.
- req changes while busy are ignored; the request is sampled again at the next IDLE edge.
- Simultaneous requests: exactly one grant is issued per round.
  - The most recently served requester becomes lowest priority.
  - Starvation-free: a continuously asserted request is served within 8 rounds.
- ptr wraps: ptr = 7 makes requester 0 first in the search; ptr = 3 gives the order 4,5,6,7,0,1,2,3.
- Arithmetic:
  - The sum wraps modulo 2^WIDTH.
  - The comparison is unsigned.
  - All three results are always produced; there is no operation select.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
  - NREQ = 8 and ID_W = 3.
  - PTR_RESET = 3'd7.
- Sub-module rr_pick: combinational; inputs req[7:0] and ptr[2:0]; outputs winner[2:0] and any.
  - Implemented as a rotate of req, a priority encode, then an add-back of the offset.
- The datapath instantiates the team's existing adder and comparator modules with #(WIDTH).
- Operand select is an indexed part-select on the latched winner.

Test Plan:
- Reset, then req = 8'b0000_0100, A2 = 5, B2 = 7 -> grant = 8'h04 one cycle later; then result_valid with id = 2, sum = 12, greater = 0, equal = 0.
- req = 8'hFF held continuously, with per-requester operands -> grants in the order 0,1,2,…,7,0, one every 3 cycles; each result_id matches the preceding grant.
- WIDTH = 32, A = 32'hFFFF_FFFF, B = 1 -> sum = 0, greater = 1, equal = 0; A = B = 32'h1234_5678 -> equal = 1, greater = 0.
- After serving requester 5, assert req = 8'b0010_0001 -> requester 0 is granted before 5.
- Assert reset during EXEC -> all outputs 0 asynchronously, no result_valid follows; a request after reset release is granted from ptr = 7.
- req pulses for one cycle while busy, then drops -> it is never granted and busy falls after RESP.

Source files
------------

// File: rtl/shared_adder_arbiter_pkg.sv
// Shared constants and state encoding for the shared adder/comparator arbiter.
package shared_adder_arbiter_pkg;

  localparam int NREQ = 8;
  localparam int ID_W = 3;
  localparam logic [ID_W-1:0] PTR_RESET = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/shared_adder_arbiter_rr_pick.sv
// Round-robin winner selection: the requester just after ptr has highest priority.
module rr_pick
  import shared_adder_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   offset;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  // Rotate so bit 0 of rot is the first requester in the search order.
  assign start = ptr + 3'd1;
  assign dbl   = {req, req};
  assign rot   = dbl[start +: NREQ];

  always_comb begin
    offset = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = ID_W'(i);
    end
  end

  assign winner = start + offset;
  assign any    = |req;

endmodule

// File: rtl/shared_adder_arbiter_units.sv
// Shared arithmetic units: a wrapping adder and an unsigned magnitude comparator.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

module comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/shared_adder_arbiter.sv
// Arbitrates 8 requesters onto one shared adder and comparator, one operation per 3 cycles.
module shared_adder_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  op_a,
  input  logic [NREQ*WIDTH-1:0]  op_b,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   result_valid,
  output logic [ID_W-1:0]        result_id,
  output logic [WIDTH-1:0]       result_sum,
  output logic                   result_greater,
  output logic                   result_equal
);

  state_t          state, next_state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic [ID_W-1:0] lat_id;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [WIDTH-1:0] sum;
  logic            gt, eq;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .any    (pick_any)
  );

  adder #(.WIDTH(WIDTH)) u_add (
    .a   (lat_a),
    .b   (lat_b),
    .sum (sum)
  );

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .a  (lat_a),
    .b  (lat_b),
    .gt (gt),
    .eq (eq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_any) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant is a one-cycle pulse; result fields persist until the next EXEC edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= PTR_RESET;
      lat_id         <= '0;
      lat_a          <= '0;
      lat_b          <= '0;
      grant          <= '0;
      result_valid   <= 1'b0;
      result_id      <= '0;
      result_sum     <= '0;
      result_greater <= 1'b0;
      result_equal   <= 1'b0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            lat_id <= pick_id;
            lat_a  <= op_a[int'(pick_id)*WIDTH +: WIDTH];
            lat_b  <= op_b[int'(pick_id)*WIDTH +: WIDTH];
            grant  <= NREQ'(1) << pick_id;
          end
        end
        EXEC: begin
          result_valid   <= 1'b1;
          result_id      <= lat_id;
          result_sum     <= sum;
          result_greater <= gt;
          result_equal   <= eq;
        end
        RESP: begin
          result_valid <= 1'b0;
          ptr          <= lat_id;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
